// File: rtl/pmc_ac_loader.sv
`default_nettype none
// ============================================================================
// Module   : pmc_ac_loader
// Purpose  : Bus-master sequencer that writes a latched NUM_REGS x 32-bit
//            analog-config image over a req/gnt/rvalid data bus.
// Options  : PMC_AC_LOADER_VERIFY_EN - read back and compare every word.
// Revision : 1.0 - initial release
// ============================================================================
module pmc_ac_loader #(
    parameter int          NUM_REGS  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [32*NUM_REGS-1:0]  cfg,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [3:0]              err_idx,
    output logic                    bus_req,
    input  logic                    bus_gnt,
    input  logic                    bus_rvalid,
    input  logic                    bus_err,
    output logic [31:0]             bus_addr,
    output logic                    bus_we,
    output logic [3:0]              bus_be,
    output logic [31:0]             bus_wdata,
    input  logic [31:0]             bus_rdata
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_WR_REQ = 3'd1;
    localparam logic [2:0] c_WR_RSP = 3'd2;
`ifdef PMC_AC_LOADER_VERIFY_EN
    localparam logic [2:0] c_RD_REQ = 3'd3;
    localparam logic [2:0] c_RD_RSP = 3'd4;
`endif
    localparam logic [2:0] c_FIN    = 3'd5;
    localparam logic [3:0] c_LAST   = 4'(NUM_REGS - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [3:0]  r_idx;
    logic        r_error;
    logic [3:0]  r_err_idx;
    logic [31:0] r_img [NUM_REGS];
    logic [31:0] w_word [16];
    logic [31:0] w_cur;
    logic        w_last;
    logic        w_fail;
    logic        w_advance;
    logic        w_rd_req;

    // Pad the image to 16 entries so the 4-bit index selects without truncation.
    for (genvar gi = 0; gi < 16; gi++) begin : g_word
        if (gi < NUM_REGS) begin : g_used
            assign w_word[gi] = r_img[gi];
        end else begin : g_pad
            assign w_word[gi] = '0;
        end
    end

    assign w_cur  = w_word[r_idx];
    assign w_last = (r_idx == c_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_fail      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            c_IDLE:   if (start) w_state_nxt = c_WR_REQ;
            c_WR_REQ: if (bus_gnt) w_state_nxt = c_WR_RSP;
            c_WR_RSP: begin
                if (bus_rvalid) begin
                    if (bus_err) begin
                        w_fail      = 1'b1;
                        w_state_nxt = c_FIN;
                    end else begin
`ifdef PMC_AC_LOADER_VERIFY_EN
                        w_state_nxt = c_RD_REQ;
`else
                        w_advance   = !w_last;
                        w_state_nxt = w_last ? c_FIN : c_WR_REQ;
`endif
                    end
                end
            end
`ifdef PMC_AC_LOADER_VERIFY_EN
            c_RD_REQ: if (bus_gnt) w_state_nxt = c_RD_RSP;
            c_RD_RSP: begin
                if (bus_rvalid) begin
                    if (bus_err || (bus_rdata != w_cur)) begin
                        w_fail      = 1'b1;
                        w_state_nxt = c_FIN;
                    end else begin
                        w_advance   = !w_last;
                        w_state_nxt = w_last ? c_FIN : c_WR_REQ;
                    end
                end
            end
`endif
            c_FIN:    w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_idx     <= '0;
            r_error   <= 1'b0;
            r_err_idx <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_img[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_IDLE && start) begin
                r_idx     <= '0;
                r_error   <= 1'b0;
                r_err_idx <= '0;
                for (int i = 0; i < NUM_REGS; i++) r_img[i] <= cfg[32*i +: 32];
            end
            if (w_fail) begin
                r_error   <= 1'b1;
                r_err_idx <= r_idx;
            end
            if (w_advance) r_idx <= r_idx + 4'd1;
        end
    end

`ifdef PMC_AC_LOADER_VERIFY_EN
    assign w_rd_req = (r_state == c_RD_REQ);
`else
    assign w_rd_req = 1'b0;
    logic w_unused_rdata;
    assign w_unused_rdata = ^bus_rdata;
`endif

    assign bus_req   = (r_state == c_WR_REQ) || w_rd_req;
    assign bus_we    = (r_state == c_WR_REQ);
    assign bus_addr  = bus_req ? (BASE_ADDR + {26'd0, r_idx, 2'b00}) : '0;
    assign bus_wdata = (r_state == c_WR_REQ) ? w_cur : '0;
    assign bus_be    = 4'hF;
    assign busy      = (r_state != c_IDLE) && (r_state != c_FIN);
    assign done      = (r_state == c_FIN);
    assign error     = r_error;
    assign err_idx   = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_pmc_ac_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmc_ac_loader
// Purpose  : Scoreboard bench for pmc_ac_loader with a randomized-delay bus slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmc_ac_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
    } exp_t;

    typedef struct {
        logic       err;
        logic [3:0] idx;
    } done_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] cfg = '0;
    logic         busy, done, error;
    logic [3:0]   err_idx;
    logic         bus_req, bus_we;
    logic         bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
    logic [31:0]  bus_addr, bus_wdata;
    logic [31:0]  bus_rdata = '0;
    logic [3:0]   bus_be;

    int n_chk = 0;
    int n_err = 0;

    exp_t  q_txn [$];
    done_t q_done [$];

    int          sl_state = 0;
    int          sl_cnt = 0;
    int          gmax = 0, rvmin = 1, rvmax = 1;
    int          err_word = -1, bad_rd_word = -1;
    logic [31:0] sl_addr, sl_wdata;
    logic        sl_we;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem [16];
    logic        hs_w1 = 1'b0;

    pmc_ac_loader #(.NUM_REGS(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg(cfg),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_err(bus_err),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept the pending request, score it against the queue and schedule the response.
    task automatic grant();
        exp_t       e;
        logic [3:0] word;
        bus_gnt <= 1'b1;
        if (q_txn.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_access: got addr %h we %b expected none", bus_addr, bus_we);
        end else begin
            e = q_txn.pop_front();
            chk("acc_addr", bus_addr, e.addr);
            chk("acc_we", {31'd0, bus_we}, {31'd0, e.we});
            if (e.we) chk("acc_wdata", bus_wdata, e.data);
        end
        word = bus_addr[5:2];
        if (bus_we) begin
            mem[word] <= bus_wdata;
            rsp_err   <= (int'(word) == err_word);
            rsp_rdata <= '0;
            if (word == 4'd1) hs_w1 <= 1'b1;
        end else begin
            rsp_err   <= 1'b0;
            rsp_rdata <= (int'(word) == bad_rd_word) ? 32'h0000_DEAD : mem[word];
        end
        sl_cnt   <= $urandom_range(rvmax, rvmin);
        sl_state <= 2;
    endtask

    // Bus slave: drives on the falling edge, checks request stability and single-outstanding.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            bus_gnt    <= 1'b0;
            bus_rvalid <= 1'b0;
            bus_err    <= 1'b0;
            bus_rdata  <= '0;
            if (rst) begin
                sl_state <= 0;
            end else begin
                case (sl_state)
                    0: if (bus_req) begin
                        sl_addr  <= bus_addr;
                        sl_wdata <= bus_wdata;
                        sl_we    <= bus_we;
                        d = $urandom_range(gmax, 0);
                        if (d == 0) grant();
                        else begin
                            sl_cnt   <= d;
                            sl_state <= 1;
                        end
                    end
                    1: begin
                        chk("req_held", {31'd0, bus_req}, 32'd1);
                        chk("addr_stable", bus_addr, sl_addr);
                        chk("wdata_stable", bus_wdata, sl_wdata);
                        chk("we_stable", {31'd0, bus_we}, {31'd0, sl_we});
                        if (sl_cnt == 1) grant();
                        else sl_cnt <= sl_cnt - 1;
                    end
                    default: begin
                        chk("single_outstanding", {31'd0, bus_req}, 32'd0);
                        if (sl_cnt == 1) begin
                            bus_rvalid <= 1'b1;
                            bus_err    <= rsp_err;
                            bus_rdata  <= rsp_rdata;
                            sl_state   <= 0;
                        end else begin
                            sl_cnt <= sl_cnt - 1;
                        end
                    end
                endcase
            end
        end
    end

    // Completion monitor.
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (q_done.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    e = q_done.pop_front();
                    chk("done_error", {31'd0, error}, {31'd0, e.err});
                    chk("done_err_idx", {28'd0, err_idx}, {28'd0, e.idx});
                    chk("done_busy", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    task automatic push_seq(input logic [127:0] img, input int ew);
        exp_t  e;
        done_t d;
        d.err = 1'b0;
        d.idx = '0;
        for (int i = 0; i < 4; i++) begin
            e.addr = 32'(4 * i);
            e.data = img[32*i +: 32];
            e.we   = 1'b1;
            q_txn.push_back(e);
            if (i == ew) begin
                d.err = 1'b1;
                d.idx = 4'(i);
                break;
            end
`ifdef PMC_AC_LOADER_VERIFY_EN
            e.we = 1'b0;
            q_txn.push_back(e);
            if (i == bad_rd_word) begin
                d.err = 1'b1;
                d.idx = 4'(i);
                break;
            end
`endif
        end
        q_done.push_back(d);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    task automatic run_seq(input logic [127:0] img, input int ew, input int bw,
                           input bit glitch, output int lat);
        err_word    = ew;
        bad_rd_word = bw;
        push_seq(img, ew);
        @(negedge clk);
        cfg   = img;
        start = 1'b1;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                chk("busy_after_start", {31'd0, busy}, 32'd1);
                chk("error_cleared", {31'd0, error}, 32'd0);
            end
            if (glitch && lat == 4) begin
                start = 1'b1;
                cfg   = ~img;
            end
            if (glitch && lat == 5) start = 1'b0;
        end while (!done && lat < 500);
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
        end
        @(negedge clk);
        chk("txn_drained", q_txn.size(), 32'd0);
        chk("done_drained", q_done.size(), 32'd0);
    endtask

    task automatic chk_mem(input logic [127:0] img);
        for (int i = 0; i < 4; i++) chk("slave_mem", mem[i], img[32*i +: 32]);
    endtask

    localparam logic [127:0] c_IMG1 = {32'h4, 32'h3, 32'h2, 32'h1};
`ifdef PMC_AC_LOADER_VERIFY_EN
    localparam int c_LAT = 17;
`else
    localparam int c_LAT = 9;
`endif

    initial begin
        int           lat;
        int           n;
        logic [127:0] imgs [3];
        imgs[0] = {32'hA5A5_0003, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000};
        imgs[1] = {32'hCAFE_F00D, 32'h8000_0001, 32'h0F0F_F0F0, 32'h7654_3210};
        imgs[2] = {32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 32'h0000_0008};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_err_idx", {28'd0, err_idx}, 32'd0);
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_we", {31'd0, bus_we}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'hF);
        rst = 1'b0;

        // Zero-wait bus: basic image and latency.
        gmax = 0; rvmin = 1; rvmax = 1;
        clear_mem();
        run_seq(c_IMG1, -1, -1, 1'b0, lat);
        chk("latency", lat, c_LAT);
        chk_mem(c_IMG1);

        // Random handshake delays; middle run also re-pulses start with a new cfg.
        gmax = 5; rvmin = 1; rvmax = 5;
        for (int k = 0; k < 3; k++) begin
            clear_mem();
            run_seq(imgs[k], -1, -1, (k == 1), lat);
            chk_mem(imgs[k]);
        end

        // Bus error on word 2 stops the sequence and stays sticky.
        gmax = 2; rvmin = 1; rvmax = 3;
        run_seq(c_IMG1, 2, -1, 1'b0, lat);
        chk("error_sticky", {31'd0, error}, 32'd1);
        chk("err_idx_sticky", {28'd0, err_idx}, 32'd2);

`ifdef PMC_AC_LOADER_VERIFY_EN
        run_seq(c_IMG1, -1, 1, 1'b0, lat);
        chk("rd_error_sticky", {31'd0, error}, 32'd1);
        clear_mem();
        run_seq(imgs[0], -1, -1, 1'b0, lat);
        chk("error_after_clean", {31'd0, error}, 32'd0);
        chk_mem(imgs[0]);
`endif

        // Reset while waiting for the word-1 write response.
        gmax = 0; rvmin = 3; rvmax = 3;
        err_word = -1; bad_rd_word = -1;
        hs_w1 = 1'b0;
        push_seq(c_IMG1, -1);
        @(negedge clk);
        cfg   = c_IMG1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!hs_w1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_word1", {31'd0, hs_w1}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_req", {31'd0, bus_req}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        q_txn.delete();
        q_done.delete();
        @(negedge clk);
        rst = 1'b0;
        gmax = 0; rvmin = 1; rvmax = 1;
        clear_mem();
        run_seq(imgs[2], -1, -1, 1'b0, lat);
        chk("latency_after_rst", lat, c_LAT);
        chk_mem(imgs[2]);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
